// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer for a small combinational ROM.
// Owns the program counter, registers each fetched word into a one-entry
// valid/ready output stage, and handles branch redirect/flush and halt.
// Optional build macro FETCH_PERF_CNT_EN adds the fetch_cnt/flush_cnt
// performance counters; without it those ports and their logic are absent.
module fetch_ctrl #(
   parameter int                  BIT_ADDR  = 32,
   parameter int                  BIT_DATO  = 32,
   parameter int                  NREG      = 16,
   parameter int                  RESET_PC  = 0,
   parameter logic [BIT_DATO-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   output logic [BIT_ADDR-1:0]       imem_addr,
   input  logic [BIT_DATO-1:0]       imem_data,
   input  logic                      branch_en,
   input  logic [BIT_ADDR-1:0]       branch_target,
   output logic [BIT_DATO-1:0]       ins,
   output logic [$clog2(NREG)-1:0]   ins_pc,
   output logic                      ins_valid,
   input  logic                      ins_ready,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]               fetch_cnt,
   output logic [15:0]               flush_cnt,
`endif
   output logic                      halted
);

   localparam int PCW = $clog2(NREG);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      HALT  = 2'd2
   } state_t;

   state_t            state, stateNext;
   logic [PCW-1:0]    pc, pcNext;
   logic [BIT_DATO-1:0] insReg, insNext;
   logic [PCW-1:0]    insPcReg, insPcNext;
   logic              validReg, validNext;
   logic              load;
   logic [PCW-1:0]    target;
   logic              unusedTgtBits;

   // Sequential PC increment that wraps at the ROM depth.
   function automatic logic [PCW-1:0] pcInc(input logic [PCW-1:0] p);
      return (p == PCW'(NREG - 1)) ? '0 : p + 1'b1;
   endfunction

   // Only the low PCW bits of a branch target address the ROM.
   assign target        = branch_target[PCW-1:0];
   assign unusedTgtBits = ^branch_target[BIT_ADDR-1:PCW];

   // The output stage may take a new word when empty or drained this cycle.
   assign load = !validReg || ins_ready;

   // ROM address comes from the PC register only, zero-extended.
   assign imem_addr = BIT_ADDR'(pc);
   assign ins       = insReg;
   assign ins_pc    = insPcReg;
   assign ins_valid = validReg;
   assign halted    = (state == HALT);

   // State, PC and output-stage registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         pc       <= PCW'(RESET_PC);
         insReg   <= '0;
         insPcReg <= '0;
         validReg <= 1'b0;
      end else begin
         state    <= stateNext;
         pc       <= pcNext;
         insReg   <= insNext;
         insPcReg <= insPcNext;
         validReg <= validNext;
      end
   end

   // Next-state and next-register logic; branch beats load and halt detection.
   always_comb begin
      stateNext = state;
      pcNext    = pc;
      insNext   = insReg;
      insPcNext = insPcReg;
      validNext = validReg;
      case (state)
         IDLE: begin
            validNext = 1'b0;
            if (branch_en) pcNext = target;
            if (start) stateNext = FETCH;
         end
         FETCH: begin
            if (branch_en) begin
               pcNext    = target;
               validNext = 1'b0;
            end else if (load) begin
               insNext   = imem_data;
               insPcNext = pc;
               validNext = 1'b1;
               if (imem_data == HALT_WORD) stateNext = HALT;
               else                        pcNext    = pcInc(pc);
            end
         end
         HALT: begin
            if (branch_en) begin
               pcNext    = target;
               validNext = 1'b0;
               stateNext = FETCH;
            end else if (ins_ready) begin
               validNext = 1'b0;
            end
         end
         default: begin
            stateNext = IDLE;
            validNext = 1'b0;
         end
      endcase
   end

`ifdef FETCH_PERF_CNT_EN
   // Saturating increment for the flush counter.
   function automatic logic [15:0] satInc16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   // Count accepted transfers (wrapping) and flushes of a valid word (saturating).
   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (validReg && ins_ready && !branch_en) fetch_cnt <= fetch_cnt + 32'd1;
         if (validReg && branch_en)               flush_cnt <= satInc16(flush_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed table-driven bench for fetch_ctrl with a
// behavioural 16-word ROM, plus hand sequences for halt and mid-run reset.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        branch_en = 1'b0;
   logic [31:0] branch_target = '0;
   logic [31:0] ins;
   logic [3:0]  ins_pc;
   logic        ins_valid;
   logic        ins_ready = 1'b0;
   logic        halted;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt;
   logic [15:0] flush_cnt;
`endif

   logic [31:0] rom [16];
   int checks = 0;
   int errors = 0;

   assign imem_data = rom[imem_addr[3:0]];

   fetch_ctrl dut (
      .clk(clk), .rst(rst), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .branch_en(branch_en), .branch_target(branch_target),
      .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid), .ins_ready(ins_ready),
`ifdef FETCH_PERF_CNT_EN
      .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt),
`endif
      .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, start, br;
      logic [31:0] tgt;
      logic        rdy;
      logic        expValid;
      logic        chkIns;
      logic [3:0]  expPc;
      logic [31:0] expIns;
      logic        expHalted;
      logic        chkAddr;
      logic [31:0] expAddr;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock: drive inputs at negedge, sample #1 after the following posedge.
   task automatic step(input logic r, input logic s, input logic b,
                       input logic [31:0] t, input logic rd);
      @(negedge clk);
      rst = r; start = s; branch_en = b; branch_target = t; ins_ready = rd;
      @(posedge clk);
      #1;
   endtask

   task automatic addV(input logic r, input logic s, input logic b, input logic [31:0] t,
                       input logic rd, input logic ev, input int pc, input logic h,
                       input logic ca, input logic [31:0] ea);
      vec_t v;
      v.rst = r; v.start = s; v.br = b; v.tgt = t; v.rdy = rd;
      v.expValid = ev; v.expHalted = h; v.chkAddr = ca; v.expAddr = ea;
      v.chkIns = 1'b0; v.expPc = 4'(pc); v.expIns = 32'h1000_0000 + 32'(pc);
      if (!r) begin
         v.chkIns = 1'b1; v.expPc = 4'd0; v.expIns = 32'h0;
      end else if (ev) begin
         v.chkIns = 1'b1;
      end
      vecs.push_back(v);
   endtask

   task automatic stepChk(input string tag, input logic r, input logic s, input logic b,
                          input logic [31:0] t, input logic rd, input logic ev,
                          input int pc, input logic [31:0] ei, input logic h);
      step(r, s, b, t, rd);
      chk({tag, " valid"}, 32'(ins_valid), 32'(ev));
      chk({tag, " halted"}, 32'(halted), 32'(h));
      if (ev) begin
         chk({tag, " ins_pc"}, 32'(ins_pc), 32'(pc));
         chk({tag, " ins"}, ins, ei);
      end
   endtask

   initial begin
      logic        prevValid;
      logic [31:0] expFetch;
      logic [15:0] expFlush;
      prevValid = 1'b0; expFetch = '0; expFlush = '0;
      for (int i = 0; i < 16; i++) rom[i] = 32'h1000_0000 + 32'(i);

      // Reset, then idle with start low.
      for (int i = 0; i < 2; i++) addV(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 5; i++) addV(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      // Start, then stream with wrap: 0..15,0..3 then 4,5.
      addV(1, 1, 0, 0, 1, 0, 0, 0, 0, 0);
      for (int k = 0; k < 22; k++) addV(1, 0, 0, 0, 1, 1, k % 16, 0, 0, 0);
      // Backpressure while word 5 is presented.
      for (int k = 0; k < 3; k++) addV(1, 0, 0, 0, 0, 1, 5, 0, 0, 0);
      for (int k = 6; k < 20; k++) addV(1, 0, 0, 0, 1, 1, k % 16, 0, 0, 0);
      // Branch flush at ins_pc 3 to target 0x2A (low bits 0xA).
      addV(1, 0, 1, 32'h0000_002A, 1, 0, 0, 0, 0, 0);
      addV(1, 0, 0, 0, 1, 1, 10, 0, 0, 0);
      addV(1, 0, 0, 0, 1, 1, 11, 0, 0, 0);

      foreach (vecs[i]) begin
         vec_t v;
         v = vecs[i];
         if (!v.rst) begin
            expFetch = '0; expFlush = '0;
         end else begin
            if (prevValid && v.rdy && !v.br) expFetch = expFetch + 32'd1;
            if (prevValid && v.br && expFlush != 16'hFFFF) expFlush = expFlush + 16'd1;
         end
         prevValid = v.expValid;
         step(v.rst, v.start, v.br, v.tgt, v.rdy);
         chk($sformatf("v%0d valid", i), 32'(ins_valid), 32'(v.expValid));
         chk($sformatf("v%0d halted", i), 32'(halted), 32'(v.expHalted));
         if (v.chkIns) begin
            chk($sformatf("v%0d ins_pc", i), 32'(ins_pc), 32'(v.expPc));
            chk($sformatf("v%0d ins", i), ins, v.expIns);
         end
         if (v.chkAddr) chk($sformatf("v%0d imem_addr", i), imem_addr, v.expAddr);
`ifdef FETCH_PERF_CNT_EN
         chk($sformatf("v%0d fetch_cnt", i), fetch_cnt, expFetch);
         chk($sformatf("v%0d flush_cnt", i), 32'(flush_cnt), 32'(expFlush));
`endif
      end

      // Halt word at address 4.
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      rom[4] = 32'hFFFF_FFFF;
      stepChk("halt start", 1, 1, 0, 0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++)
         stepChk($sformatf("halt run%0d", k), 1, 0, 0, 0, 1, 1, k, 32'h1000_0000 + 32'(k), 0);
      stepChk("halt present", 1, 0, 0, 0, 1, 1, 4, 32'hFFFF_FFFF, 1);
      for (int k = 0; k < 3; k++)
         stepChk($sformatf("halt hold%0d", k), 1, 0, 0, 0, 0, 1, 4, 32'hFFFF_FFFF, 1);
      stepChk("halt accept", 1, 0, 0, 0, 1, 0, 0, 0, 1);
      for (int k = 0; k < 10; k++) begin
         stepChk($sformatf("halt idle%0d", k), 1, k == 3, 0, 0, 1, 0, 0, 0, 1);
         chk($sformatf("halt addr%0d", k), imem_addr, 32'd4);
      end
      stepChk("halt branch", 1, 0, 1, 32'h0, 1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++)
         stepChk($sformatf("restart%0d", k), 1, 0, 0, 0, 1, 1, k, 32'h1000_0000 + 32'(k), 0);

      // Reset while a word is valid and a branch is requested.
      stepChk("midrst", 0, 0, 1, 32'h5, 1, 0, 0, 0, 0);
      chk("midrst addr", imem_addr, 32'd0);
      chk("midrst ins", ins, 32'd0);
      chk("midrst ins_pc", 32'(ins_pc), 32'd0);
      rom[4] = 32'h1000_0004;
      for (int k = 0; k < 3; k++) begin
         stepChk($sformatf("postrst idle%0d", k), 1, 0, 0, 0, 1, 0, 0, 0, 0);
         chk($sformatf("postrst addr%0d", k), imem_addr, 32'd0);
      end
      stepChk("resume start", 1, 1, 0, 0, 1, 0, 0, 0, 0);
      stepChk("resume w0", 1, 0, 0, 0, 1, 1, 0, 32'h1000_0000, 0);
      stepChk("resume w1", 1, 0, 0, 0, 1, 1, 1, 32'h1000_0001, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
